// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply/divide unit.
//
// Signed and unsigned multiply (shift-add) and divide (restoring
// shift-subtract) on WIDTH-bit operands, one step per clock. Signed
// operations run on magnitudes; the sign is applied on the final cycle.
// A result appears WIDTH+1 cycles after the start edge.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      operation request (accepted in IDLE or DONE)
//   Operation  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B       multiplicand/dividend, multiplier/divisor
//   busy       high from the accepting edge until the completion edge
//   done       one-cycle completion pulse
//   Hi, Lo     product high/low half, or remainder/quotient
//   DivZero    last completed divide had a zero divisor
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | WIDTH iteration steps, then one sign-fixup/result cycle
// DONE  | result valid, done high; start here chains a new operation

module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;      // steps remaining; zero means fixup cycle
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic             b_zero;
    logic [WIDTH-1:0] opd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] a_hold;   // raw dividend, returned as Hi on divide by zero

    // Operand magnitudes at the capture edge
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        in_neg_a = Operation[0] & A[WIDTH-1];
        in_neg_b = Operation[0] & B[WIDTH-1];
        mag_a    = in_neg_a ? -A : A;
        mag_b    = in_neg_b ? -B : B;
    end

    // One iteration step for each operation class
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        // Shift the next dividend bit into the partial remainder; the top
        // bit of the trial value matters only for the compare.
        div_trial = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, opd};
        div_diff  = div_trial[WIDTH-1:0] - opd;
        if (is_div) begin
            nxt_hi = div_ge ? div_diff : div_trial[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied on the fixup cycle
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    always_comb begin
        prod_s = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_s  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem_s  = neg_a ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            b_zero  <= 1'b0;
            opd     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            a_hold  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= CW'(WIDTH);
                        is_div <= Operation[1];
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        b_zero <= (B == '0);
                        a_hold <= A;
                        acc_hi <= '0;
                        if (Operation[1]) begin
                            acc_lo <= mag_a;
                            opd    <= mag_b;
                        end else begin
                            acc_lo <= mag_b;
                            opd    <= mag_a;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    if (cnt != '0) begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt - CW'(1);
                    end else begin
                        if (!is_div) begin
                            {Hi, Lo} <= prod_s;
                            DivZero  <= 1'b0;
                        end else if (b_zero) begin
                            Lo      <= '1;
                            Hi      <= a_hold;
                            DivZero <= 1'b1;
                        end else begin
                            Lo      <= quo_s;
                            Hi      <= rem_s;
                            DivZero <= 1'b0;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter -- self-checking bench for mdu_iter at WIDTH=32.
// Expected results come from plain 64-bit integer arithmetic.

module tb_mdu_iter;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   Operation = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         DivZero;

    int tests_run = 0;
    int tests_failed = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Operation (Operation),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Hi        (Hi),
        .Lo        (Lo),
        .DivZero   (DivZero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (op)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: p = 64'(sa * sb);
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        if (op[1] && b == 0) dz = 1'b1;
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Issue one operation and watch it to completion. Operands are scrambled
    // after the accepting edge; optionally start is re-pulsed mid-calculation.
    // Returns at #1 after the done edge (lat = -1 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int repulse_at,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; Operation = op; A = a; B = b;
        @(posedge clk); #1;
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        start = 1'b0;
        Operation = 2'($urandom); A = $urandom; B = $urandom;
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                start = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            if (k == repulse_at) begin
                start = 1'b1;
                Operation = 2'b00; A = 32'd9; B = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, DivZero} !== 3'b000 || Hi !== '0 || Lo !== '0) begin
            tests_failed++;
            $display("FAIL reset_state busy=%b done=%b dz=%b Hi=%h Lo=%h required all zero",
                     busy, done, DivZero, Hi, Lo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, lat, bc);
        tests_run++;
        if (lat != LAT || bc != LAT) begin
            tests_failed++;
            $display("FAIL multu_timing lat=%0d busy_cycles=%0d required %0d/%0d", lat, bc, LAT, LAT);
        end
        tests_run++;
        if (Hi !== 32'h1 || Lo !== 32'hFFFF_FFFE || busy !== 1'b0 || DivZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL multu_result Hi=%h Lo=%h busy=%b dz=%b required 00000001 fffffffe 0 0",
                     Hi, Lo, busy, DivZero);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || Hi !== 32'h1 || Lo !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL multu_hold done=%b Hi=%h Lo=%h required 0 00000001 fffffffe", done, Hi, Lo);
        end
    endtask

    task automatic test_mult();
        int lat, bc;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, lat, bc);
        tests_run++;
        if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1 || lat != LAT) begin
            tests_failed++;
            $display("FAIL mult_neg Hi=%h Lo=%h lat=%0d required ffffffff fffffff1 %0d", Hi, Lo, lat, LAT);
        end
    endtask

    task automatic test_div();
        int lat, bc;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, lat, bc);
        tests_run++;
        if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF || DivZero !== 1'b0 || lat != LAT) begin
            tests_failed++;
            $display("FAIL div_neg Lo=%h Hi=%h dz=%b lat=%0d required fffffffd ffffffff 0 %0d",
                     Lo, Hi, DivZero, lat, LAT);
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bc);
        tests_run++;
        if (Lo !== 32'h8000_0000 || Hi !== 32'h0 || DivZero !== 1'b0 || lat != LAT) begin
            tests_failed++;
            $display("FAIL div_overflow Lo=%h Hi=%h dz=%b lat=%0d required 80000000 00000000 0 %0d",
                     Lo, Hi, DivZero, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(2'b10, 32'd100, 32'd0, 0, lat, bc);
        tests_run++;
        if (Lo !== 32'hFFFF_FFFF || Hi !== 32'd100 || DivZero !== 1'b1 || lat != LAT) begin
            tests_failed++;
            $display("FAIL divzero Lo=%h Hi=%h dz=%b lat=%0d required ffffffff 00000064 1 %0d",
                     Lo, Hi, DivZero, lat, LAT);
        end
        // Issued immediately: start is sampled on the edge leaving DONE.
        run_op(2'b00, 32'd3, 32'd4, 0, lat, bc);
        tests_run++;
        if (lat != LAT || DivZero !== 1'b0 || Lo !== 32'd12 || Hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL back_to_back lat=%0d dz=%b Lo=%h Hi=%h required %0d 0 0000000c 00000000",
                     lat, DivZero, Lo, Hi, LAT);
        end
    endtask

    task automatic test_start_in_calc();
        int lat, bc, extra;
        run_op(2'b10, 32'd100, 32'd7, 5, lat, bc);
        tests_run++;
        if (Lo !== 32'd14 || Hi !== 32'd2 || lat != LAT) begin
            tests_failed++;
            $display("FAIL start_in_calc Lo=%0d Hi=%0d lat=%0d required 14 2 %0d", Lo, Hi, lat, LAT);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        tests_run++;
        if (extra != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done extra_done=%0d busy=%b required 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid_calc();
        int dones;
        @(negedge clk);
        start = 1'b1; Operation = 2'b00; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || Hi !== '0 || Lo !== '0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_calc busy=%b Hi=%h Lo=%h done=%b required 0 0 0 0", busy, Hi, Lo, done);
        end
        // start held high during reset must not be accepted
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_during_reset busy=%b required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        tests_run++;
        if (dones != 0 || Hi !== '0 || Lo !== '0) begin
            tests_failed++;
            $display("FAIL abort_no_done active_cycles=%0d Hi=%h Lo=%h required 0 0 0", dones, Hi, Lo);
        end
    endtask

    task automatic test_random();
        int lat, bc, sel;
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
        logic        ez;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 3) b = -32'($urandom_range(1, 9));
            model(op, a, b, eh, el, ez);
            run_op(op, a, b, 0, lat, bc);
            tests_run++;
            if (Hi !== eh || Lo !== el || DivZero !== ez || lat != LAT || bc != LAT) begin
                tests_failed++;
                $display("FAIL random op=%0d A=%h B=%h got Hi=%h Lo=%h dz=%b lat=%0d busy=%0d required %h %h %b %0d %0d",
                         op, a, b, Hi, Lo, DivZero, lat, bc, eh, el, ez, LAT, LAT);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_back_to_back();
        test_start_in_calc();
        test_reset_mid_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  operation request, sampled on rising clk.
REQ-005 Port: Operation  input  2  op select: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 Port: A  input  WIDTH  multiplicand or dividend.
REQ-007 Port: B  input  WIDTH  multiplier or divisor.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  single-cycle completion pulse.
REQ-010 Port: Hi  output  WIDTH  product upper half, or remainder.
REQ-011 Port: Lo  output  WIDTH  product lower half, or quotient.
REQ-012 Port: DivZero  output  1  divisor was zero on the last completed divide.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 start=1 sampled at edge E0 while in IDLE or DONE SHALL capture A, B and Operation, move the FSM to CALC, and set busy=1 from E0.
REQ-015 start while in CALC SHALL be ignored, and A/B/Operation changes after E0 SHALL NOT affect the result.
REQ-016 CALC SHALL perform exactly one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, for WIDTH cycles.
REQ-017 At edge E0+WIDTH+1 the unit SHALL update Hi, Lo and DivZero, clear busy, set done=1 and enter DONE.
REQ-018 DONE SHALL last one cycle, then return to IDLE; done=0 in every state except DONE.
REQ-019 start=1 sampled while in DONE SHALL begin a new operation at that edge (back-to-back, no bubble).
REQ-020 Hi, Lo and DivZero SHALL hold their values until the next completion or reset.
REQ-021 Signed ops SHALL operate on operand magnitudes and apply sign correction after the last step, within the same cycle budget.
REQ-022 MULT/MULTU SHALL give {Hi,Lo} = the full 2*WIDTH-bit product, two's complement for MULT.
REQ-023 DIV/DIVU SHALL give Lo = quotient truncated toward zero and Hi = remainder carrying the dividend's sign.
REQ-024 A divide with B=0 SHALL give Lo = all ones, Hi = A, DivZero=1, with unchanged latency.
REQ-025 DivZero SHALL be 0 after any multiply and after any divide with nonzero B.
REQ-026 DIV of the most-negative value by -1 SHALL give Lo = the most-negative value, Hi=0, DivZero=0.
REQ-027 Latency SHALL be WIDTH+1 cycles from E0 to the done edge, independent of operand values.

Reset
REQ-028 rst=1 SHALL, asynchronously, force state=IDLE, busy=0, done=0, Hi=0, Lo=0, DivZero=0 and clear all internal accumulators.
REQ-029 rst asserted mid-CALC SHALL abort the operation: no done pulse and no result update.
REQ-030 start SHALL be ignored on any edge where rst=1; the first start accepted is on the first edge after rst deasserts.

Verification (WIDTH=32)
REQ-031 MULTU, A=0xFFFFFFFF, B=2 -> done 33 cycles after E0, Hi=0x00000001, Lo=0xFFFFFFFE, busy high for exactly 33 cycles.
REQ-032 MULT, A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1 (-15).
REQ-033 DIV, A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); then DIV, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-034 DIVU, A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100, DivZero=1; then a MULTU issued in the DONE cycle -> DivZero=0 and done exactly 33 cycles later.
REQ-035 DIVU, A=100, B=7 with start re-pulsed in CALC cycle 5 carrying different operands -> Lo=14, Hi=2, and exactly one done pulse.
REQ-036 rst pulsed at CALC cycle 10 of MULTU 6x7 -> busy=0, Hi=Lo=0 immediately, and no done pulse for the following 40 cycles.
